// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution window path: tap indices, widths, counter sizing.
// No logic; latency n/a.
// Backpressure n/a.
package conv_pkg;

    localparam int NTAPS  = 9;
    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_MC = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;

    localparam int PIX_W    = 16;
    localparam int SUM_GROW = 4;
    localparam int SUM_W    = PIX_W + SUM_GROW;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/line_buf_ram.sv
// One image line of pixels, addressed by column; async read, write on clock edge.
// Latency: read is combinational, write lands next edge (read-before-write at the same address).
// Backpressure: none; writes only when the owner asserts iWE.
module line_buf_ram
    import conv_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8
) (
    input  logic                  iCLK,
    input  logic                  iWE,
    input  logic [clog2(W)-1:0]   iADDR,
    input  logic [N-1:0]          iWDATA,
    output logic [N-1:0]          oRDATA
);

    logic [N-1:0] mem_q [W];

    assign oRDATA = mem_q[iADDR];

    always_ff @(posedge iCLK) begin
        if (iWE) begin
            mem_q[iADDR] <= iWDATA;
        end
    end

endmodule

// File: rtl/conv_window_reader.sv
// Raster pixel stream in, 3x3 window out via two line buffers; optional tap sum under WIN_SUM_EN.
// Latency: 1 cycle from the accept of pixel (r>=2, c>=2) to its window.
// Backpressure: oREADY = !oVALID || iREADY; a stalled window freezes all state.
module conv_window_reader
    import conv_pkg::*;
#(
    parameter int N = PIX_W,
    parameter int W = 8,
    parameter int H = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iVALID,
    input  logic [N-1:0]     idata,
    output logic             oREADY,
    output logic             oVALID,
    input  logic             iREADY,
    output logic [9*N-1:0]   owin,
    output logic             oEOF
`ifdef WIN_SUM_EN
    ,
    output logic [N+SUM_GROW-1:0] osum
`endif
);

    localparam int CW = clog2(W);
    localparam int RW = clog2(H);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [N-1:0]  win_q [NTAPS];
    logic [N-1:0]  win_d [NTAPS];
    logic          vld_q, vld_d;
    logic          eof_q, eof_d;

    logic          accept;
    logic          qualify;
    logic          last_pix;
    logic [N-1:0]  lb0_rd;
    logic [N-1:0]  lb1_rd;

    assign oREADY   = !vld_q || iREADY;
    assign accept   = iVALID && oREADY;
    assign qualify  = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_pix = (row_q == RW'(H - 1)) && (col_q == CW'(W - 1));

    // LB0 inherits LB1's old pixel while LB1 takes the new one: both shift down a line.
    line_buf_ram #(.N(N), .W(W)) u_lb0 (
        .iCLK   (iCLK),
        .iWE    (accept),
        .iADDR  (col_q),
        .iWDATA (lb1_rd),
        .oRDATA (lb0_rd)
    );

    line_buf_ram #(.N(N), .W(W)) u_lb1 (
        .iCLK   (iCLK),
        .iWE    (accept),
        .iADDR  (col_q),
        .iWDATA (idata),
        .oRDATA (lb1_rd)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        win_d = win_q;
        vld_d = vld_q;
        eof_d = eof_q;
        if (accept) begin
            if (col_q == CW'(W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            win_d[TAP_TL] = win_q[TAP_TC];
            win_d[TAP_TC] = win_q[TAP_TR];
            win_d[TAP_TR] = lb0_rd;
            win_d[TAP_ML] = win_q[TAP_MC];
            win_d[TAP_MC] = win_q[TAP_MR];
            win_d[TAP_MR] = lb1_rd;
            win_d[TAP_BL] = win_q[TAP_BC];
            win_d[TAP_BC] = win_q[TAP_BR];
            win_d[TAP_BR] = idata;
            vld_d = qualify;
            eof_d = qualify && last_pix;
        end else if (iREADY) begin
            vld_d = 1'b0;
            eof_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            col_q <= '0;
            row_q <= '0;
            win_q <= '{default: '0};
            vld_q <= 1'b0;
            eof_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
            vld_q <= vld_d;
            eof_q <= eof_d;
        end
    end

    assign owin   = {win_q[TAP_BR], win_q[TAP_BC], win_q[TAP_BL],
                     win_q[TAP_MR], win_q[TAP_MC], win_q[TAP_ML],
                     win_q[TAP_TR], win_q[TAP_TC], win_q[TAP_TL]};
    assign oVALID = vld_q;
    assign oEOF   = eof_q;

`ifdef WIN_SUM_EN
    localparam int SW = N + SUM_GROW;

    logic [SW-1:0] sum_q, sum_d;

    // Summed from the next-window taps so the sum registers alongside owin.
    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            sum_d = SW'(win_d[TAP_TL]) + SW'(win_d[TAP_TC]) + SW'(win_d[TAP_TR])
                  + SW'(win_d[TAP_ML]) + SW'(win_d[TAP_MC]) + SW'(win_d[TAP_MR])
                  + SW'(win_d[TAP_BL]) + SW'(win_d[TAP_BC]) + SW'(win_d[TAP_BR]);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign osum = sum_q;
`endif

endmodule

// File: tb/tb_conv_window_reader.sv
// Randomised-gap, randomised-data bench for conv_window_reader (W=H=4, N=16) against an image-array model.
// Build with WIN_SUM_EN defined to also check osum.
module tb_conv_window_reader;
    import conv_pkg::*;

    localparam int N      = 16;
    localparam int W      = 4;
    localparam int H      = 4;
    localparam int WB     = 9 * N;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          ivalid;
    logic [N-1:0]  idata;
    logic          oready;
    logic          ovalid;
    logic          iready;
    logic [WB-1:0] owin;
    logic          oeof;
`ifdef WIN_SUM_EN
    logic [N+3:0]  osum;
`endif

    always #5 clk = ~clk;

    conv_window_reader #(.N(N), .W(W), .H(H)) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .iVALID (ivalid),
        .idata  (idata),
        .oREADY (oready),
        .oVALID (ovalid),
        .iREADY (iready),
        .owin   (owin),
        .oEOF   (oeof)
`ifdef WIN_SUM_EN
        ,
        .osum   (osum)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the current frame as an image plus the pending window.
    logic [N-1:0]  img [H][W];
    int            mr;
    int            mc;
    bit            exp_vld;
    bit            exp_eof;
    logic [WB-1:0] exp_win;
    logic [N+3:0]  exp_sum;
    int            win_in_frame;
    bit            seq_data;
    bit            pix_fresh;
    logic [N-1:0]  cur_pix;
    int            sum_tab [4] = '{45, 54, 81, 90};

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window of the value-(W*r+c) image whose top-left tap sits at (r0, c0).
    function automatic logic [WB-1:0] seq_win(input int r0, input int c0);
        logic [WB-1:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                w[N*(3*rr+cc) +: N] = N'(W*(r0+rr) + (c0+cc));
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        ivalid = 1'b0;
        iready = 1'b0;
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        mr           = 0;
        mc           = 0;
        exp_vld      = 1'b0;
        exp_eof      = 1'b0;
        win_in_frame = 0;
        pix_fresh    = 1'b1;
        chk("rst_ovalid", ovalid, 0);
        chk("rst_oeof",   oeof,   0);
        chk("rst_owin",   owin,   0);
`ifdef WIN_SUM_EN
        chk("rst_osum",   osum,   0);
`endif
    endtask

    task automatic run(input int npix, input int vld_pct, input int rdy_pct, input bit stall_first);
        int  sent;
        int  cycles;
        int  stall_left;
        bit  stalled_once;
        bit  exp_rdy;
        bit  acc;
        sent         = 0;
        cycles       = 0;
        stall_left   = 0;
        stalled_once = 1'b0;
        pix_fresh    = 1'b1;
        while ((sent < npix || exp_vld) && cycles < BUDGET) begin
            chk("ovalid", ovalid, exp_vld);
            chk("oeof",   oeof,   exp_eof);
            if (exp_vld) begin
                chk("owin", owin, exp_win);
`ifdef WIN_SUM_EN
                chk("osum", osum, exp_sum);
`endif
            end

            if (stall_first && exp_vld && !stalled_once) begin
                stall_left   = 3;
                stalled_once = 1'b1;
            end
            if (stall_left > 0) begin
                iready = 1'b0;
                stall_left--;
            end else begin
                iready = ($urandom_range(1, 100) <= rdy_pct);
            end
            ivalid = (sent < npix) && ($urandom_range(1, 100) <= vld_pct);
            if (pix_fresh) begin
                cur_pix   = seq_data ? N'(W*mr + mc) : N'($urandom);
                pix_fresh = 1'b0;
            end
            idata = cur_pix;
            #1;
            exp_rdy = !exp_vld || iready;
            chk("oready", oready, exp_rdy);

            if (exp_vld && iready) begin
                win_in_frame++;
                if (seq_data) begin
                    if (win_in_frame == 1) chk("first_win", owin, seq_win(0, 0));
                    if (exp_eof)           chk("last_win",  owin, seq_win(H-3, W-3));
`ifdef WIN_SUM_EN
                    if (win_in_frame <= 4) chk("osum_tab", osum, sum_tab[win_in_frame-1]);
`endif
                end
                if (exp_eof) begin
                    chk("win_count", win_in_frame, (W-2)*(H-2));
                    win_in_frame = 0;
                end
            end

            acc = ivalid && exp_rdy;
            if (acc) begin
                img[mr][mc] = cur_pix;
                if (mr >= 2 && mc >= 2) begin
                    exp_vld = 1'b1;
                    exp_eof = (mr == H-1) && (mc == W-1);
                    exp_sum = '0;
                    for (int rr = 0; rr < 3; rr++)
                        for (int cc = 0; cc < 3; cc++) begin
                            exp_win[N*(3*rr+cc) +: N] = img[mr-2+rr][mc-2+cc];
                            exp_sum = exp_sum + (N+4)'(img[mr-2+rr][mc-2+cc]);
                        end
                end else begin
                    exp_vld = 1'b0;
                    exp_eof = 1'b0;
                end
                if (mc == W-1) begin
                    mc = 0;
                    mr = (mr == H-1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
                sent++;
                pix_fresh = 1'b1;
            end else if (iready) begin
                exp_vld = 1'b0;
                exp_eof = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        chk("run_budget", cycles < BUDGET, 1);
        ivalid = 1'b0;
        iready = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        ivalid       = 1'b0;
        iready       = 1'b0;
        idata        = '0;
        seq_data     = 1'b1;
        pix_fresh    = 1'b1;
        cur_pix      = '0;
        exp_win      = '0;
        exp_sum      = '0;

        do_reset();
        // Full-rate frame: first window after pixel 10, four windows, EOF on the last.
        run(16, 100, 100, 1'b0);
        // Three-cycle downstream stall on the first window of the next frame.
        run(16, 100, 100, 1'b1);
        // Input gaps around 50%.
        run(16, 50, 100, 1'b0);
        // Random pixel data with random gaps on both sides.
        seq_data = 1'b0;
        run(32, 70, 60, 1'b0);
        // Reset mid-frame after pixel 9, then two clean frames.
        seq_data = 1'b1;
        run(10, 100, 100, 1'b0);
        do_reset();
        run(32, 100, 100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
